// File: rtl/stripe_rr_scheduler.sv
// Round-robin byte scheduler feeding a two-lane striper: grants one FWFT FIFO at a
// time for up to BURST_LEN bytes and pads odd bursts so each owner starts on lane 0.
module stripe_rr_scheduler #(
  parameter int          NREQ      = 4,
  parameter int          BURST_LEN = 8,
  parameter logic [7:0]  PAD_BYTE  = 8'hF7,
  localparam int         SEL_W     = $clog2(NREQ)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [NREQ-1:0]   fifo_empty,
  input  logic [8*NREQ-1:0] fifo_data,
  input  logic              pause,
  output logic [NREQ-1:0]   fifo_pop,
  output logic              valid_out,
  output logic [7:0]        data_out,
  output logic              pad_flag,
  output logic [SEL_W-1:0]  grant,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, XFER, PAD} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [7:0]         data_q, data_d;
  logic               pad_q, pad_d;
  logic               busy_q, busy_d;

  logic               pop_en;
  logic               pad_issue;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [7:0]         src_byte [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    assign src_byte[gi] = fifo_data[8*gi +: 8];
    assign fifo_pop[gi] = pop_en && (grant_q == SEL_W'(gi));
  end

  // Scan from the farthest candidate back to the nearest so the nearest non-empty wins.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = int'(last_grant_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!fifo_empty[cand]) begin
        pick_found = 1'b1;
        pick_idx   = SEL_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    pop_en       = 1'b0;
    pad_issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!pause && pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!pause) begin
          if (!fifo_empty[grant_q]) begin
            pop_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(BURST_LEN)) begin
              state_d      = IDLE;
              last_grant_d = grant_q;
            end
          end else if (cnt_q[0]) begin
            state_d = PAD;
          end else begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      PAD: begin
        if (!pause) begin
          pad_issue    = 1'b1;
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing leaves the FIFOs while reset is held; the burst is simply abandoned.
    if (reset) begin
      pop_en    = 1'b0;
      pad_issue = 1'b0;
    end
  end

  always_comb begin
    valid_d = pop_en | pad_issue;
    pad_d   = pad_issue;
    busy_d  = (state_d != IDLE);
    data_d  = data_q;
    if (pop_en)         data_d = src_byte[grant_q];
    else if (pad_issue) data_d = PAD_BYTE;
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_W'(NREQ - 1);
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      pad_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      pad_q        <= pad_d;
      busy_q       <= busy_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign pad_flag  = pad_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_stripe_rr_scheduler.sv
// Directed bench for stripe_rr_scheduler: FIFO sources modelled as small arrays,
// delivered bytes collected and compared against hand-computed sequences.
module tb_stripe_rr_scheduler;

  localparam int         NREQ      = 4;
  localparam int         BURST_LEN = 8;
  localparam logic [7:0] PAD_BYTE  = 8'hF7;

  logic              clk_2f = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   fifo_empty;
  logic [8*NREQ-1:0] fifo_data;
  logic              pause;
  logic [NREQ-1:0]   fifo_pop;
  logic              valid_out;
  logic [7:0]        data_out;
  logic              pad_flag;
  logic [1:0]        grant;
  logic              busy;

  stripe_rr_scheduler #(.NREQ(NREQ), .BURST_LEN(BURST_LEN), .PAD_BYTE(PAD_BYTE)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .pause     (pause),
    .fifo_pop  (fifo_pop),
    .valid_out (valid_out),
    .data_out  (data_out),
    .pad_flag  (pad_flag),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk_2f = ~clk_2f;

  logic [7:0]      mem [NREQ][40];
  int              head [NREQ];
  int              tail [NREQ];
  logic [NREQ-1:0] pop_seen;
  logic [7:0]      rx_data [$];
  bit              rx_pad [$];
  int              rx_grant [$];
  bit              vhist [$];
  int              n_vec = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic load(input int s, input logic [7:0] b);
    mem[s][tail[s]] = b;
    tail[s]++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rx_data.delete();
    rx_pad.delete();
    rx_grant.delete();
    vhist.delete();
  endtask

  // One clock cycle: present FIFO heads, sample the pop, advance FIFOs, sample outputs.
  task automatic tick();
    for (int i = 0; i < NREQ; i++) begin
      fifo_empty[i]      = (head[i] == tail[i]);
      fifo_data[8*i +: 8] = (head[i] == tail[i]) ? 8'h00 : mem[i][head[i]];
    end
    #1;
    pop_seen = fifo_pop;
    @(posedge clk_2f);
    for (int i = 0; i < NREQ; i++)
      if (pop_seen[i]) head[i]++;
    #1;
    vhist.push_back(valid_out);
    if (valid_out) begin
      rx_data.push_back(data_out);
      rx_pad.push_back(pad_flag);
      rx_grant.push_back(int'(grant));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    repeat (2) tick();
    reset = 1'b0;
    clear_all();
  endtask

  initial begin
    int first_v;
    int npops;
    int pause_left;
    int paused;
    int b;
    int k;
    logic [7:0] exp_b;

    reset = 1'b1;
    pause = 1'b0;
    fifo_empty = '1;
    fifo_data = '0;
    clear_all();

    // Reset held with every source non-empty
    for (int i = 0; i < NREQ; i++) load(i, 8'hA0 + 8'(i));
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_pop_zero", 32'(pop_seen), 32'h0);
    end
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pad", 32'(pad_flag), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    reset = 1'b0;
    tick();
    check("first_idle_pop", 32'(pop_seen), 32'h0);
    check("first_grant", 32'(grant), 32'h0);
    check("first_busy", 32'(busy), 32'h1);
    tick();
    check("first_pop_src0", 32'(pop_seen), 32'h1);
    check("first_byte", 32'(data_out), 32'hA0);

    // Odd burst of three bytes from source 0 gets one pad
    do_reset();
    load(0, 8'hA1); load(0, 8'hA2); load(0, 8'hA3);
    repeat (12) tick();
    check("odd_count", 32'(rx_data.size()), 32'd4);
    if (rx_data.size() == 4) begin
      check("odd_b0", 32'(rx_data[0]), 32'hA1);
      check("odd_b1", 32'(rx_data[1]), 32'hA2);
      check("odd_b2", 32'(rx_data[2]), 32'hA3);
      check("odd_b3", 32'(rx_data[3]), 32'(PAD_BYTE));
      check("odd_padflags", {28'h0, rx_pad[0], rx_pad[1], rx_pad[2], rx_pad[3]}, 32'h1);
    end
    check("odd_busy_end", 32'(busy), 32'h0);
    check("odd_valid_end", 32'(valid_out), 32'h0);

    // Round-robin between sources 1 and 3, 16 bytes each
    clear_all();
    for (int i = 0; i < 16; i++) begin
      load(1, 8'h11 + 8'(i));
      load(3, 8'h33 + 8'(i));
    end
    repeat (45) tick();
    check("rr_count", 32'(rx_data.size()), 32'd32);
    if (rx_data.size() == 32) begin
      for (int j = 0; j < 32; j++) begin
        b = j / 8;
        k = (b / 2) * 8 + (j % 8);
        exp_b = (b % 2 == 0) ? 8'h11 + 8'(k) : 8'h33 + 8'(k);
        check($sformatf("rr_byte%0d", j), 32'(rx_data[j]), 32'(exp_b));
        check($sformatf("rr_grant%0d", j), 32'(rx_grant[j]), (b % 2 == 0) ? 32'd1 : 32'd3);
        check($sformatf("rr_nopad%0d", j), 32'(rx_pad[j]), 32'h0);
      end
    end
    first_v = -1;
    for (int p = 0; p < vhist.size(); p++)
      if (first_v < 0 && vhist[p]) first_v = p;
    check("rr_started", 32'(first_v >= 0), 32'h1);
    if (first_v >= 0 && first_v + 35 <= vhist.size()) begin
      for (int p = 0; p < 35; p++)
        check($sformatf("rr_valid_t%0d", p), 32'(vhist[first_v + p]), 32'((p % 9) != 8));
    end

    // Pause for two cycles after the third pop of source 2
    clear_all();
    for (int i = 0; i < 8; i++) load(2, 8'h20 + 8'(i));
    npops = 0;
    pause_left = 0;
    paused = 0;
    for (int t = 0; t < 30; t++) begin
      pause = (pause_left > 0);
      tick();
      if (pause) begin
        check("pause_pop", 32'(pop_seen), 32'h0);
        check("pause_valid", 32'(valid_out), 32'h0);
        pause_left--;
        paused++;
      end else if (pop_seen != '0) begin
        check("pause_src2_pop", 32'(pop_seen), 32'h4);
        npops++;
        if (npops == 3) pause_left = 2;
      end
    end
    pause = 1'b0;
    check("pause_cycles", 32'(paused), 32'd2);
    check("pause_count", 32'(rx_data.size()), 32'd8);
    if (rx_data.size() == 8)
      for (int j = 0; j < 8; j++)
        check($sformatf("pause_byte%0d", j), 32'(rx_data[j]), 32'h20 + 32'(j));

    // Even drain: two bytes from source 1, no pad
    clear_all();
    load(1, 8'hB1); load(1, 8'hB2);
    repeat (8) tick();
    check("even_count", 32'(rx_data.size()), 32'd2);
    if (rx_data.size() == 2) begin
      check("even_b0", 32'(rx_data[0]), 32'hB1);
      check("even_b1", 32'(rx_data[1]), 32'hB2);
      check("even_pads", {30'h0, rx_pad[0], rx_pad[1]}, 32'h0);
      check("even_grant", 32'(rx_grant[0]), 32'd1);
    end
    check("even_busy_end", 32'(busy), 32'h0);

    // Reset in the middle of a source-3 burst
    clear_all();
    for (int i = 0; i < 8; i++) load(3, 8'hC0 + 8'(i));
    npops = 0;
    for (int t = 0; t < 20 && npops < 3; t++) begin
      tick();
      if (pop_seen != '0) npops++;
    end
    check("mid_pops_reached", 32'(npops), 32'd3);
    check("mid_grant", 32'(grant), 32'd3);
    load(0, 8'h5A);
    reset = 1'b1;
    tick();
    check("mid_rst_pop", 32'(pop_seen), 32'h0);
    check("mid_rst_valid", 32'(valid_out), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();
    check("mid_idle_pop", 32'(pop_seen), 32'h0);
    check("mid_regrant", 32'(grant), 32'd0);
    tick();
    check("mid_src0_pop", 32'(pop_seen), 32'h1);
    check("mid_src0_byte", 32'(data_out), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
